// File: rtl/reg_wb_pkg.sv
// reg_wb_pkg: shared types and sizing helpers for the register write-back block.
//   wb_req_t  : one pending register write (destination + data) at the default widths
//   WB_CNT_W  : width of an occupancy count able to hold 0..WB_DEPTH
//   cnt_width : count width for an arbitrary queue depth
//   ptr_width : circular-buffer pointer width for an arbitrary queue depth
package reg_wb_pkg;

   localparam int WB_W     = 8;
   localparam int WB_D     = 3;
   localparam int WB_DEPTH = 2;
   localparam int WB_CNT_W = $clog2(WB_DEPTH + 1);

   typedef struct packed {
      logic [WB_D-1:0] dst;
      logic [WB_W-1:0] data;
   } wb_req_t;

   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   // A one-entry queue still needs a 1-bit pointer to index storage.
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: DEPTH-entry in-order circular buffer of pending register writes.
// Entries are packed as {dst, data}. Up to two pushes (push_a older than
// push_b) and one pop per cycle. Full/empty come from the count, never from
// pointer equality, so DEPTH need not be a power of two.
//   clk_sys, rst_b      : clock, async active-low reset
//   push_cnt, push_a/b  : number of entries pushed this cycle (0..2) and payloads
//   pop                 : consume the head entry (ignored when empty)
//   head_valid, head    : oldest entry
//   count               : current occupancy
//   occupied, ent_dst   : per-slot occupied flag and destination register
module wb_fifo
   import reg_wb_pkg::*;
#(
   parameter int W     = WB_W,
   parameter int D     = WB_D,
   parameter int DEPTH = WB_DEPTH,
   localparam int EW    = D + W,
   localparam int CNT_W = cnt_width(DEPTH),
   localparam int PTR_W = ptr_width(DEPTH)
) (
   input  logic               clk_sys,
   input  logic               rst_b,
   input  logic [1:0]         push_cnt,
   input  logic [EW-1:0]      push_a,
   input  logic [EW-1:0]      push_b,
   input  logic               pop,
   output logic               head_valid,
   output logic [EW-1:0]      head,
   output logic [CNT_W-1:0]   count,
   output logic [DEPTH-1:0]   occupied,
   output logic [DEPTH*D-1:0] ent_dst
);

   logic [EW-1:0]    mem_q [DEPTH];
   logic [EW-1:0]    mem_d [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign head_valid = (count_q != '0);
   assign head       = mem_q[rd_ptr_q];
   assign count      = count_q;
   assign do_pop     = pop && head_valid;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      if (push_cnt != 2'd0) begin
         mem_d[wr_ptr_q] = push_a;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      // second push lands in the slot after the first one
      if (push_cnt[1]) begin
         mem_d[wr_ptr_d] = push_b;
         wr_ptr_d        = ptr_inc(wr_ptr_d);
      end
      rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q + CNT_W'(push_cnt) - CNT_W'(do_pop);
   end

   // A slot is live when its distance from the read pointer is below the count.
   always_comb begin
      occupied = '0;
      ent_dst  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         occupied[i]      = ((i + DEPTH - int'(rd_ptr_q)) % DEPTH) < int'(count_q);
         ent_dst[i*D +: D] = mem_q[i][EW-1 -: D];
      end
   end

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: merges ALU results and load returns onto the register file's
// single write port. The oldest queued write always goes first; otherwise a
// fresh request takes the port directly (load before ALU, since the load is
// the older instruction). Anything that misses the port is queued in program
// order, so the youngest write to a register always lands last.
//   CLK, Reset_n                   : clock, async active-low reset
//   AluValid/AluReg/AluValue       : ALU result request
//   LdValid/LdReg/LdValue          : load return request
//   QueryReg                       : decode hazard lookup
//   WriteReg/WReg/WriteValue       : register-file write port
//   Stall                          : queue full, upstream must hold off
//   QueryHit                       : a queued write targets QueryReg
//   Overflow                       : sticky, a request was dropped while stalled
module reg_writeback
   import reg_wb_pkg::*;
#(
   parameter int W     = WB_W,
   parameter int D     = WB_D,
   parameter int DEPTH = WB_DEPTH
) (
   input  logic         CLK,
   input  logic         Reset_n,
   input  logic         AluValid,
   input  logic [D-1:0] AluReg,
   input  logic [W-1:0] AluValue,
   input  logic         LdValid,
   input  logic [D-1:0] LdReg,
   input  logic [W-1:0] LdValue,
   input  logic [D-1:0] QueryReg,
   output logic         WriteReg,
   output logic [D-1:0] WReg,
   output logic [W-1:0] WriteValue,
   output logic         Stall,
   output logic         QueryHit,
   output logic         Overflow
);

   localparam int EW    = D + W;
   localparam int CNT_W = cnt_width(DEPTH);

   logic               head_valid;
   logic [EW-1:0]      head;
   logic [CNT_W-1:0]   count;
   logic [DEPTH-1:0]   occupied;
   logic [DEPTH*D-1:0] ent_dst;

   logic [1:0]    push_cnt;
   logic [EW-1:0] push_a, push_b;
   logic          pop;
   logic          full, accept;
   logic          wr_en;
   logic [EW-1:0] wr_req;
   logic [EW-1:0] ld_req, alu_req;
   logic          overflow_q, overflow_d;

   assign ld_req  = {LdReg, LdValue};
   assign alu_req = {AluReg, AluValue};
   assign full    = (count == CNT_W'(DEPTH));
   assign accept  = Reset_n && !full;

   always_comb begin
      wr_en    = 1'b0;
      wr_req   = '0;
      pop      = 1'b0;
      push_cnt = 2'd0;
      push_a   = '0;
      push_b   = '0;

      if (Reset_n) begin
         if (head_valid) begin
            wr_en  = 1'b1;
            wr_req = head;
            pop    = 1'b1;
         end else if (LdValid && accept) begin
            wr_en  = 1'b1;
            wr_req = ld_req;
         end else if (AluValid && accept) begin
            wr_en  = 1'b1;
            wr_req = alu_req;
         end
      end

      // Queue whatever did not win the port, oldest first. With the queue
      // non-full and at most one slot freed per push pair, two pushes only
      // happen while the head is popping, so capacity is never exceeded.
      if (accept) begin
         if (head_valid) begin
            if (LdValid && AluValid) begin
               push_cnt = 2'd2;
               push_a   = ld_req;
               push_b   = alu_req;
            end else if (LdValid) begin
               push_cnt = 2'd1;
               push_a   = ld_req;
            end else if (AluValid) begin
               push_cnt = 2'd1;
               push_a   = alu_req;
            end
         end else if (LdValid && AluValid) begin
            push_cnt = 2'd1;
            push_a   = alu_req;
         end
      end
   end

   assign overflow_d = overflow_q || (full && (AluValid || LdValid));

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= overflow_d;
      end
   end

   // Only queued entries count as hazards; direct writes land this cycle.
   always_comb begin
      QueryHit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (occupied[i] && (ent_dst[i*D +: D] == QueryReg)) begin
            QueryHit = 1'b1;
         end
      end
   end

   assign WriteReg   = wr_en;
   assign WReg       = wr_req[EW-1 -: D];
   assign WriteValue = wr_req[W-1:0];
   assign Stall      = full;
   assign Overflow   = overflow_q;

   wb_fifo #(
      .W     (W),
      .D     (D),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_sys    (CLK),
      .rst_b      (Reset_n),
      .push_cnt   (push_cnt),
      .push_a     (push_a),
      .push_b     (push_b),
      .pop        (pop),
      .head_valid (head_valid),
      .head       (head),
      .count      (count),
      .occupied   (occupied),
      .ent_dst    (ent_dst)
   );

endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: scoreboard bench for reg_writeback. The reference model
// keeps the not-yet-written requests as a plain program-order list: each
// cycle a request is dropped if the list is full, otherwise appended (load
// before ALU), and the oldest listed request is written. Accepted requests
// are pushed to a scoreboard queue; a negedge monitor pops it whenever the
// DUT writes.
module tb_reg_writeback;
   import reg_wb_pkg::*;

   localparam int W     = WB_W;
   localparam int D     = WB_D;
   localparam int DEPTH = WB_DEPTH;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         alu_valid, ld_valid;
   logic [D-1:0] alu_reg, ld_reg, query_reg;
   logic [W-1:0] alu_value, ld_value;
   logic         write_reg, stall, query_hit, overflow;
   logic [D-1:0] w_reg;
   logic [W-1:0] write_value;

   wb_req_t pend[$];
   wb_req_t sb[$];
   bit      ovf_m;
   logic    exp_we, exp_stall, exp_hit, exp_ovf;
   bit      chk_en = 1'b0;
   int      checks = 0;
   int      errors = 0;

   always #5 clk = ~clk;

   reg_writeback #(.W(W), .D(D), .DEPTH(DEPTH)) dut (
      .CLK        (clk),
      .Reset_n    (rst_n),
      .AluValid   (alu_valid),
      .AluReg     (alu_reg),
      .AluValue   (alu_value),
      .LdValid    (ld_valid),
      .LdReg      (ld_reg),
      .LdValue    (ld_value),
      .QueryReg   (query_reg),
      .WriteReg   (write_reg),
      .WReg       (w_reg),
      .WriteValue (write_value),
      .Stall      (stall),
      .QueryHit   (query_hit),
      .Overflow   (overflow)
   );

   task automatic cycle(input logic lv, input logic [D-1:0] lr, input logic [W-1:0] lval,
                        input logic av, input logic [D-1:0] ar, input logic [W-1:0] aval,
                        input logic [D-1:0] qr);
      wb_req_t r;
      @(posedge clk);
      #1;
      ld_valid  = lv;  ld_reg  = lr;  ld_value  = lval;
      alu_valid = av;  alu_reg = ar;  alu_value = aval;
      query_reg = qr;
      exp_stall = (pend.size() == DEPTH);
      exp_hit   = 1'b0;
      foreach (pend[i]) if (pend[i].dst == qr) exp_hit = 1'b1;
      exp_ovf   = ovf_m;
      if (exp_stall) begin
         if (lv || av) ovf_m = 1'b1;
      end else begin
         if (lv) begin r.dst = lr; r.data = lval; pend.push_back(r); sb.push_back(r); end
         if (av) begin r.dst = ar; r.data = aval; pend.push_back(r); sb.push_back(r); end
      end
      exp_we = (pend.size() != 0);
      if (exp_we) void'(pend.pop_front());
   endtask

   task automatic idle(input logic [D-1:0] qr);
      cycle(1'b0, '0, '0, 1'b0, '0, '0, qr);
   endtask

   task automatic dual();
      cycle(1'b1, D'($urandom), W'($urandom), 1'b1, D'($urandom), W'($urandom), D'($urandom));
   endtask

   task automatic rand_cycle(input bit honor_stall);
      logic lv, av;
      logic [D-1:0] qr;
      lv = 1'($urandom_range(0, 1));
      av = 1'($urandom_range(0, 1));
      if (honor_stall && pend.size() == DEPTH) begin
         lv = 1'b0;
         av = 1'b0;
      end
      qr = (pend.size() != 0 && $urandom_range(0, 1) == 1) ? pend[$].dst : D'($urandom);
      cycle(lv, D'($urandom), W'($urandom), av, D'($urandom), W'($urandom), qr);
   endtask

   // Reset is held for one full cycle with both valids high, which must be ignored.
   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n     = 1'b0;
      ld_valid  = 1'b1;
      alu_valid = 1'b1;
      pend.delete();
      sb.delete();
      ovf_m     = 1'b0;
      exp_we    = 1'b0;
      exp_stall = 1'b0;
      exp_hit   = 1'b0;
      exp_ovf   = 1'b0;
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      ld_valid  = 1'b0;
      alu_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         checks++;
         if (write_reg !== exp_we) begin
            errors++;
            $display("FAIL write_en: got %0b expected %0b at %0t", write_reg, exp_we, $time);
         end
         if (write_reg === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write: got R%0d=%0h with nothing expected at %0t",
                        w_reg, write_value, $time);
            end else begin
               wb_req_t e;
               e = sb.pop_front();
               if (w_reg !== e.dst || write_value !== e.data) begin
                  errors++;
                  $display("FAIL write_data: got R%0d=%0h expected R%0d=%0h at %0t",
                           w_reg, write_value, e.dst, e.data, $time);
               end
            end
         end
         checks++;
         if (stall !== exp_stall) begin
            errors++;
            $display("FAIL stall: got %0b expected %0b at %0t", stall, exp_stall, $time);
         end
         checks++;
         if (query_hit !== exp_hit) begin
            errors++;
            $display("FAIL query_hit: got %0b expected %0b at %0t", query_hit, exp_hit, $time);
         end
         checks++;
         if (overflow !== exp_ovf) begin
            errors++;
            $display("FAIL overflow: got %0b expected %0b at %0t", overflow, exp_ovf, $time);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n     = 1'b0;
      ld_valid  = 1'b0; ld_reg  = '0; ld_value  = '0;
      alu_valid = 1'b0; alu_reg = '0; alu_value = '0;
      query_reg = '0;
      ovf_m     = 1'b0;
      exp_we    = 1'b0; exp_stall = 1'b0; exp_hit = 1'b0; exp_ovf = 1'b0;
      chk_en    = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      idle(3'd3);
      // ALU only, direct write
      cycle(1'b0, '0, '0, 1'b1, 3'd3, 8'h5A, 3'd3);
      idle(3'd3);
      // simultaneous to R2: load wins, ALU queued and visible to the hazard lookup
      cycle(1'b1, 3'd2, 8'h11, 1'b1, 3'd2, 8'h22, 3'd2);
      idle(3'd2);
      idle(3'd2);
      // fill, then overflow while stalled, then drain
      dual();
      dual();
      cycle(1'b0, '0, '0, 1'b1, 3'd5, 8'hEE, 3'd5);
      repeat (3) idle(D'($urandom));
      // pointer wrap: dual/idle pairs
      for (int i = 0; i < 10; i++) begin
         dual();
         idle(D'($urandom));
      end
      // mid-drain reset with two entries queued
      dual();
      dual();
      do_reset();
      repeat (3) idle(D'($urandom));
      // R0 is ordinary
      cycle(1'b1, 3'd0, 8'h01, 1'b1, 3'd0, 8'h02, 3'd0);
      idle(3'd0);
      for (int i = 0; i < 400; i++) rand_cycle(1'b1);
      do_reset();
      for (int i = 0; i < 300; i++) rand_cycle(1'b0);
      repeat (DEPTH + 2) idle('0);

      @(negedge clk);
      #1;
      chk_en = 1'b0;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected writes never appeared, expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
